// File: rtl/id_stage_pipe.sv
// id_stage_pipe
// Decode stage of the pipelined ARM core. It contains:
//   - an IF/ID register with a valid/ready handshake
//   - an NREG-entry register file with a writeback bypass. Reads of PC_REG
//     return id_pc + PC_OFFSET.
//   - immediate extension
//   - an ID/EX output register with a valid/ready handshake
// The instruction decoder is external and combinational. It looks at id_instr
// and returns regsrc/immsrc in the same cycle.
//
// Ports:
//   clk, reset             clock; asynchronous active-low reset
//   in_valid/in_ready      fetch handshake
//   in_instr/in_pc         fetched instruction and its address
//   flush                  kills the instructions in ID and ID/EX (branch taken)
//   id_instr               instruction held in ID, sent to the decoder
//   regsrc/immsrc          decoder select lines
//   wb_we/wb_addr/wb_data  register-file writeback port
//   out_valid/out_ready    execute handshake
//   out_instr/out_pc       registered instruction and PC
//   out_srca/out_srcb      registered operands
//   out_imm                registered extended immediate
module id_stage_pipe #(
  parameter int DW        = 32,
  parameter int NREG      = 16,
  parameter int AW        = $clog2(NREG),
  parameter int PC_REG    = 15,
  parameter int PC_OFFSET = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [DW-1:0] in_pc,
  input  logic          flush,
  output logic [31:0]   id_instr,
  input  logic [1:0]    regsrc,
  input  logic [1:0]    immsrc,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [DW-1:0] out_pc,
  output logic [DW-1:0] out_srca,
  output logic [DW-1:0] out_srcb,
  output logic [DW-1:0] out_imm
);

  localparam logic [AW-1:0] PC_IDX = AW'(PC_REG);
  localparam logic [DW-1:0] PC_ADD = DW'(PC_OFFSET);

  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] rf [NREG];

  logic          advance;
  logic          in_fire;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] pc_read;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [DW-1:0] imm_ext;

  // ID/EX can take new data when it is empty or when its current contents
  // leave this cycle.
  assign advance  = !out_valid || out_ready;
  assign in_ready = !id_valid || advance;
  assign in_fire  = in_valid && in_ready;

  assign ra1 = regsrc[0] ? PC_IDX : AW'(id_instr[19:16]);
  assign ra2 = regsrc[1] ? AW'(id_instr[15:12]) : AW'(id_instr[3:0]);

  assign pc_read = id_pc + PC_ADD;

  // The reads are combinational from the ID contents. A write that lands
  // while ID is stalled is therefore seen before the instruction moves on.
  always_comb begin
    rd1 = rf[ra1];
    if (ra1 == PC_IDX) begin
      rd1 = pc_read;
    end else if (wb_we && (wb_addr == ra1)) begin
      rd1 = wb_data;
    end
  end

  always_comb begin
    rd2 = rf[ra2];
    if (ra2 == PC_IDX) begin
      rd2 = pc_read;
    end else if (wb_we && (wb_addr == ra2)) begin
      rd2 = wb_data;
    end
  end

  always_comb begin
    imm_ext = '0;
    unique case (immsrc)
      2'b00: imm_ext = DW'(id_instr[7:0]);
      2'b01: imm_ext = DW'(id_instr[11:0]);
      2'b10: imm_ext = {{(DW-26){id_instr[23]}}, id_instr[23:0], 2'b00};
      default: imm_ext = '0;
    endcase
  end

  // IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (in_fire) begin
      id_valid <= 1'b1;
      id_instr <= in_instr;
      id_pc    <= in_pc;
    end else if (advance) begin
      id_valid <= 1'b0;
    end
  end

  // ID/EX register. When flush is high the data may still load, but
  // out_valid is cleared, so that data is never used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_srca  <= '0;
      out_srcb  <= '0;
      out_imm   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid <= id_valid;
      end
      if (advance) begin
        out_instr <= id_instr;
        out_pc    <= id_pc;
        out_srca  <= rd1;
        out_srcb  <= rd2;
        out_imm   <= imm_ext;
      end
    end
  end

  // Register file. PC_REG has no storage behind it: reads of PC_REG take the
  // PC path above, so writes to it are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_we && (wb_addr != PC_IDX)) begin
      rf[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [31:0] id_instr;
  logic [1:0]  regsrc;
  logic [1:0]  immsrc;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_srca;
  logic [31:0] out_srcb;
  logic [31:0] out_imm;

  int checks;
  int failures;

  id_stage_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .id_instr  (id_instr),
    .regsrc    (regsrc),
    .immsrc    (immsrc),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_srca  (out_srca),
    .out_srcb  (out_srcb),
    .out_imm   (out_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_we = 1'b0;
  endtask

  // Sends one instruction and returns at the first negedge where the
  // instruction is in the ID/EX register.
  task automatic run_one(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [1:0] rs, input logic [1:0] is);
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; regsrc = rs; immsrc = is;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++;
    if ({out_instr, out_pc, out_srca, out_srcb, out_imm} !== 160'd0) begin
      failures++; $display("FAIL rst_out_data got=%h exp=0", {out_instr, out_pc, out_srca, out_srcb, out_imm});
    end
    checks++;
    if (id_instr !== 32'd0) begin failures++; $display("FAIL rst_id_instr got=%h exp=0", id_instr); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++;
    @(negedge clk);
    reset = 1'b1;
    // mid-stream: fill rf[3], put an instruction into ID/EX, then reset
    wr(4'd3, 32'd5);
    run_one(32'hE0830000, 32'h10, 2'b00, 2'b00);
    if (out_valid !== 1'b1 || out_srca !== 32'd5) begin
      failures++; $display("FAIL rst_pre got=%b/%h exp=1/00000005", out_valid, out_srca);
    end
    checks++;
    #2 reset = 1'b0;
    #1;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_srca !== 32'd0 || id_instr !== 32'd0) begin
      failures++; $display("FAIL rst_async_data got=%h/%h exp=0/0", out_srca, id_instr);
    end
    checks++;
    @(negedge clk);
    reset = 1'b1;
    run_one(32'hE0830000, 32'h10, 2'b00, 2'b00);
    if (out_valid !== 1'b1 || out_srca !== 32'd0) begin
      failures++; $display("FAIL rst_rf3_cleared got=%b/%h exp=1/00000000", out_valid, out_srca);
    end
    checks++;
  endtask

  task automatic test_regfile;
    wr(4'd2, 32'h1234);
    wr(4'd3, 32'd5);
    wr(4'd1, 32'h77);
    run_one(32'hE0821003, 32'h20, 2'b00, 2'b00);
    if (out_valid !== 1'b1 || out_instr !== 32'hE0821003 || out_pc !== 32'h20) begin
      failures++; $display("FAIL rf_ctrl got=%b/%h/%h exp=1/e0821003/00000020", out_valid, out_instr, out_pc);
    end
    checks++;
    if (out_srca !== 32'h1234) begin failures++; $display("FAIL rf_srca got=%h exp=00001234", out_srca); end
    checks++;
    if (out_srcb !== 32'd5) begin failures++; $display("FAIL rf_srcb got=%h exp=00000005", out_srcb); end
    checks++;
    if (out_imm !== 32'h3) begin failures++; $display("FAIL rf_imm got=%h exp=00000003", out_imm); end
    checks++;
  endtask

  task automatic test_bypass;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hE0821003; in_pc = 32'h200; regsrc = 2'b00; immsrc = 2'b00;
    @(negedge clk);
    in_valid = 1'b0; wb_we = 1'b1; wb_addr = 4'd2; wb_data = 32'hCAFE;
    @(negedge clk);
    wb_we = 1'b0;
    if (out_srca !== 32'hCAFE) begin failures++; $display("FAIL byp_srca got=%h exp=0000cafe", out_srca); end
    checks++;
    // the write to R15 must not reach the PC read
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hE08F200F; in_pc = 32'h100;
    wb_we = 1'b1; wb_addr = 4'd15; wb_data = 32'hDEAD;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    wb_we = 1'b0;
    if (out_srca !== 32'h108 || out_srcb !== 32'h108) begin
      failures++; $display("FAIL byp_r15 got=%h/%h exp=00000108/00000108", out_srca, out_srcb);
    end
    checks++;
    run_one(32'hE0821003, 32'h40, 2'b00, 2'b00);
    if (out_srca !== 32'hCAFE || out_srcb !== 32'd5) begin
      failures++; $display("FAIL byp_rf_kept got=%h/%h exp=0000cafe/00000005", out_srca, out_srcb);
    end
    checks++;
  endtask

  task automatic test_regsrc;
    run_one(32'hE0821003, 32'h300, 2'b11, 2'b00);
    if (out_srca !== 32'h308 || out_srcb !== 32'h77) begin
      failures++; $display("FAIL regsrc got=%h/%h exp=00000308/00000077", out_srca, out_srcb);
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    regsrc = 2'b00; immsrc = 2'b00; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        if (out_valid !== 1'b1 || out_instr !== (32'hE1A00000 | 32'(k - 2)) || out_pc !== 32'(32'h400 + 4 * (k - 2))) begin
          failures++; $display("FAIL b2b_%0d got=%b/%h/%h exp=1/%h/%h", k - 2, out_valid, out_instr, out_pc,
                               32'hE1A00000 | 32'(k - 2), 32'(32'h400 + 4 * (k - 2)));
        end
        checks++;
      end
      if (k < 4) begin
        in_valid = 1'b1; in_instr = 32'hE1A00000 | 32'(k); in_pc = 32'(32'h400 + 4 * k);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    checks++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hAAAA0001; in_pc = 32'h500;
    @(negedge clk);
    in_instr = 32'hBBBB0002; in_pc = 32'h504;
    @(negedge clk);
    in_instr = 32'hCCCC0003; in_pc = 32'h508;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (out_valid !== 1'b1 || out_instr !== 32'hAAAA0001 || id_instr !== 32'hBBBB0002 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold_%0d got=%b/%h/%h/%b exp=1/aaaa0001/bbbb0002/0", k, out_valid, out_instr, id_instr, in_ready);
      end
      checks++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    if (in_ready !== 1'b1 || out_instr !== 32'hAAAA0001) begin
      failures++; $display("FAIL bp_release got=%b/%h exp=1/aaaa0001", in_ready, out_instr);
    end
    checks++;
    @(negedge clk);
    in_valid = 1'b0;
    if (out_valid !== 1'b1 || out_instr !== 32'hBBBB0002) begin
      failures++; $display("FAIL bp_b got=%b/%h exp=1/bbbb0002", out_valid, out_instr);
    end
    checks++;
    @(negedge clk);
    if (out_valid !== 1'b1 || out_instr !== 32'hCCCC0003 || out_pc !== 32'h508) begin
      failures++; $display("FAIL bp_c got=%b/%h/%h exp=1/cccc0003/00000508", out_valid, out_instr, out_pc);
    end
    checks++;
    @(negedge clk);
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    checks++;
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h11110001; in_pc = 32'h600;
    @(negedge clk);
    in_instr = 32'h22220002; in_pc = 32'h604;
    @(negedge clk);
    in_instr = 32'h33330003; in_pc = 32'h608; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_out_valid got=%b exp=0", out_valid); end
    checks++;
    in_instr = 32'h44440004; in_pc = 32'h60C;
    @(negedge clk);
    in_valid = 1'b0;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_id_killed got=%b/%h exp=0", out_valid, out_instr); end
    checks++;
    @(negedge clk);
    if (out_valid !== 1'b1 || out_instr !== 32'h44440004 || out_pc !== 32'h60C) begin
      failures++; $display("FAIL fl_next got=%b/%h/%h exp=1/44440004/0000060c", out_valid, out_instr, out_pc);
    end
    checks++;
    @(negedge clk);
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_drain got=%b exp=0", out_valid); end
    checks++;
  endtask

  task automatic test_imm;
    run_one(32'hEAFFFFFE, 32'h700, 2'b00, 2'b10);
    if (out_imm !== 32'hFFFFFFF8) begin failures++; $display("FAIL imm_br_neg got=%h exp=fffffff8", out_imm); end
    checks++;
    run_one(32'hEA000010, 32'h700, 2'b00, 2'b10);
    if (out_imm !== 32'h40) begin failures++; $display("FAIL imm_br_pos got=%h exp=00000040", out_imm); end
    checks++;
    run_one(32'hE3A00ABC, 32'h700, 2'b00, 2'b01);
    if (out_imm !== 32'hABC) begin failures++; $display("FAIL imm_12 got=%h exp=00000abc", out_imm); end
    checks++;
    run_one(32'hE3A00ABC, 32'h700, 2'b00, 2'b00);
    if (out_imm !== 32'hBC) begin failures++; $display("FAIL imm_8 got=%h exp=000000bc", out_imm); end
    checks++;
    run_one(32'hE3A00ABC, 32'h700, 2'b00, 2'b11);
    if (out_imm !== 32'h0) begin failures++; $display("FAIL imm_zero got=%h exp=00000000", out_imm); end
    checks++;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    regsrc = 2'b00; immsrc = 2'b00; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_regfile();
    test_bypass();
    test_regsrc();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_imm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
